// File: rtl/exe_24.sv
// Gate motor controller: one push button toggles open/close/reverse, limit switches stop the motor.
// Optional run-time watchdog enabled by defining MOTOR_TIMEOUT_EN (adds FALHA state).
module exe_24
`ifdef MOTOR_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 1000)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic fcc_i,
  input  logic fca_i,
  output logic abrir_o,
  output logic fechar_o
);

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTO   = 3'd2,
    FECHANDO = 3'd3,
    FALHA    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   btn_q;
  logic   press;
  logic   motor_on;

  // A held button yields one press; btn_q resets low so a button held through reset counts once.
  assign press    = btn_i & ~btn_q;
  assign motor_on = (state_q == ABRINDO) || (state_q == FECHANDO);

`ifdef MOTOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          timeout;

  assign timeout = motor_on && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Cleared on every state change so each run (including a reversal) gets a full budget.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || !motor_on) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FECHADO;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_i;
    end
  end

  // Only the limit relevant to the current direction is examined; it beats a same-cycle press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FECHADO: begin
        if (press) state_d = ABRINDO;
      end
      ABRINDO: begin
        if (fca_i) state_d = ABERTO;
`ifdef MOTOR_TIMEOUT_EN
        else if (timeout) state_d = FALHA;
`endif
        else if (press) state_d = FECHANDO;
      end
      ABERTO: begin
        if (press) state_d = FECHANDO;
      end
      FECHANDO: begin
        if (fcc_i) state_d = FECHADO;
`ifdef MOTOR_TIMEOUT_EN
        else if (timeout) state_d = FALHA;
`endif
        else if (press) state_d = ABRINDO;
      end
`ifdef MOTOR_TIMEOUT_EN
      FALHA: begin
        if (press) state_d = FECHANDO;
      end
`endif
      default: state_d = FECHADO;
    endcase
  end

  assign abrir_o  = (state_q == ABRINDO);
  assign fechar_o = (state_q == FECHANDO);

endmodule

// File: tb/tb_exe_24.sv
// Directed bench for exe_24: expected {abrir_o, fechar_o} pushed when a step is driven,
// popped and checked 1 ns after the clock edge that acts on it.
module tb_exe_24;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic btn_i;
  logic fcc_i;
  logic fca_i;
  logic abrir_o;
  logic fechar_o;

  logic [1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

`ifdef MOTOR_TIMEOUT_EN
  exe_24 #(.TIMEOUT_CYCLES(8)) dut (
`else
  exe_24 dut (
`endif
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_i),
    .fcc_i   (fcc_i),
    .fca_i   (fca_i),
    .abrir_o (abrir_o),
    .fechar_o(fechar_o)
  );

  // clock / reset
  always #10 clk_i = ~clk_i;

  task automatic check_now(input string tag, input logic [1:0] expected);
    logic [1:0] observed;
    observed = {abrir_o, fechar_o};
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed {abrir,fechar}=%b expected %b", tag, observed, expected);
    end
  endtask

  // driver: inputs change on the falling edge, result checked after the next rising edge
  task automatic step(input string tag, input logic b, input logic c, input logic a,
                      input logic [1:0] expected);
    logic [1:0] e;
    @(negedge clk_i);
    btn_i = b;
    fcc_i = c;
    fca_i = a;
    exp_q.push_back(expected);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard empty, observed %b expected entry", tag, {abrir_o, fechar_o});
    end else begin
      e = exp_q.pop_front();
      check_now(tag, e);
    end
  endtask

  initial begin
    int idle;
    rst_ni = 1'b0;
    btn_i  = 1'b0;
    fcc_i  = 1'b1;
    fca_i  = 1'b0;

    // reset held 100 ns, outputs must stay low
    #25 check_now("reset_mid", 2'b00);
    #70 check_now("reset_end", 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("idle_closed", 1'b0, 1'b1, 1'b0, 2'b00);

    // open, then hit open limit
    step("press_open",   1'b1, 1'b1, 1'b0, 2'b10);
    step("opening",      1'b0, 1'b0, 1'b0, 2'b10);
    step("open_limit",   1'b0, 1'b0, 1'b1, 2'b00);
    idle = $urandom_range(1, 4);
    for (int i = 0; i < idle; i++) step("open_idle", 1'b0, 1'b0, 1'b1, 2'b00);

    // close from ABERTO, limit drop does not matter
    step("press_close",  1'b1, 1'b0, 1'b1, 2'b01);
    step("closing",      1'b0, 1'b0, 1'b0, 2'b01);

    // reverse during closing, then open limit
    step("reverse_open", 1'b1, 1'b0, 1'b0, 2'b10);
    step("open_limit2",  1'b0, 1'b0, 1'b1, 2'b00);

    // close fully: press then closed limit
    step("press_close2", 1'b1, 1'b0, 1'b1, 2'b01);
    step("closed_limit", 1'b0, 1'b1, 1'b0, 2'b00);

    // held button: exactly one transition, no reversal
    step("hold_0", 1'b1, 1'b1, 1'b0, 2'b10);
    for (int i = 1; i < 10; i++) step("hold_n", 1'b1, 1'b0, 1'b0, 2'b10);
    step("hold_release", 1'b0, 1'b0, 1'b0, 2'b10);

    // press and open limit together: limit wins, press discarded
    step("press_vs_fca", 1'b1, 1'b0, 1'b1, 2'b00);
    step("after_fca",    1'b0, 1'b0, 1'b1, 2'b00);

    // press and closed limit together while closing
    step("press_close3", 1'b1, 1'b0, 1'b1, 2'b01);
    step("closing3",     1'b0, 1'b0, 1'b0, 2'b01);
    step("press_vs_fcc", 1'b1, 1'b1, 1'b0, 2'b00);
    step("after_fcc",    1'b0, 1'b1, 1'b0, 2'b00);

    // asynchronous reset mid-motion
    step("press_open4",  1'b1, 1'b1, 1'b0, 2'b10);
    step("opening4",     1'b0, 1'b0, 1'b0, 2'b10);
    @(negedge clk_i);
    #3 rst_ni = 1'b0;
    #1 check_now("async_reset", 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_reset",   1'b0, 1'b0, 1'b0, 2'b00);

`ifdef MOTOR_TIMEOUT_EN
    // watchdog: abrir_o high for exactly 8 cycles without a limit
    step("to_press", 1'b1, 1'b0, 1'b0, 2'b10);
    for (int i = 1; i < 8; i++) step("to_run", 1'b0, 1'b0, 1'b0, 2'b10);
    step("to_fault",  1'b0, 1'b0, 1'b0, 2'b00);
    step("to_fault2", 1'b0, 1'b0, 1'b0, 2'b00);
    step("to_close",  1'b1, 1'b0, 1'b0, 2'b01);
`endif

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit reached expected bench completion");
    $fatal(1, "bench time limit");
  end

endmodule
